// File: rtl/weight_ser_tx.sv
// weight_ser_tx: streams feat+1 trained weight words LSB-first, highest index first, back-to-back.
// Optional build macro WEIGHT_TX_PARITY_EN appends an even-parity bit after every word.
module weight_ser_tx #(
  parameter int LENGTH       = 16,
  parameter int MAX_FEATURES = 15,
  parameter int IDX_WIDTH    = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [IDX_WIDTH-1:0] feat,
  output logic                 rd_en,
  output logic [IDX_WIDTH-1:0] rd_addr,
  input  logic [LENGTH-1:0]    rd_data,
  output logic                 S_out,
  output logic                 S_valid,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           o_dbg_state
);

  // Handshakes: start is a one-cycle request honoured only in IDLE (ignored while busy
  // and in the FIN cycle); the weight RAM returns rd_data the cycle after rd_en=1;
  // S_out is meaningful only while S_valid=1, and S_valid has no gaps for a whole stream.

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] FIN   = 3'd4;

`ifdef WEIGHT_TX_PARITY_EN
  localparam int WORD_CYC = LENGTH + 1;
`else
  localparam int WORD_CYC = LENGTH;
`endif
  localparam int CNT_W = $clog2(WORD_CYC);

  // Prefetch issues three slots before the word ends so the next word lands without a gap.
  localparam logic [CNT_W-1:0] C_PF   = CNT_W'(WORD_CYC - 3);
  localparam logic [CNT_W-1:0] C_HOLD = CNT_W'(WORD_CYC - 2);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WORD_CYC - 1);

  logic [2:0]           r_state;
  logic [IDX_WIDTH-1:0] r_idx;
  logic [LENGTH-1:0]    r_shreg;
  logic [LENGTH-1:0]    r_hold;
  logic [CNT_W-1:0]     r_bitcnt;
  logic [IDX_WIDTH-1:0] r_last_addr;

  logic                 w_in_shift;
  logic                 w_prefetch;
  logic                 w_bit;
  logic [IDX_WIDTH-1:0] w_rd_addr;
  logic [IDX_WIDTH-1:0] w_feat;

  assign w_feat = (feat > IDX_WIDTH'(MAX_FEATURES)) ? IDX_WIDTH'(MAX_FEATURES) : feat;

  assign w_in_shift = (r_state == SHIFT);
  assign w_prefetch = w_in_shift && (r_bitcnt == C_PF) && (r_idx != '0);

  always_comb begin
    w_rd_addr = r_last_addr;
    if (r_state == FETCH)
      w_rd_addr = r_idx;
    else if (w_prefetch)
      w_rd_addr = r_idx - IDX_WIDTH'(1);
  end

`ifdef WEIGHT_TX_PARITY_EN
  logic r_par;
  assign w_bit = (r_bitcnt == CNT_W'(LENGTH)) ? r_par : r_shreg[0];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      r_par <= 1'b0;
    else if (r_state == LOAD)
      r_par <= ^rd_data;
    else if (w_in_shift && (r_bitcnt == C_LAST) && (r_idx != '0))
      r_par <= ^r_hold;
  end
`else
  assign w_bit = r_shreg[0];
`endif

  assign rd_en       = (r_state == FETCH) || w_prefetch;
  assign rd_addr     = w_rd_addr;
  assign S_valid     = w_in_shift;
  assign S_out       = w_in_shift & w_bit;
  assign busy        = (r_state == FETCH) || (r_state == LOAD) || w_in_shift;
  assign done        = (r_state == FIN);
  assign o_dbg_state = r_state;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_shreg     <= '0;
      r_hold      <= '0;
      r_bitcnt    <= '0;
      r_last_addr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_idx   <= w_feat;
            r_state <= FETCH;
          end
        end
        FETCH: r_state <= LOAD;
        LOAD: begin
          r_shreg  <= rd_data;
          r_bitcnt <= '0;
          r_state  <= SHIFT;
        end
        SHIFT: begin
          if ((r_bitcnt == C_HOLD) && (r_idx != '0))
            r_hold <= rd_data;
          if (r_bitcnt == C_LAST) begin
            r_bitcnt <= '0;
            if (r_idx == '0) begin
              r_state <= FIN;
            end else begin
              r_shreg <= r_hold;
              r_idx   <= r_idx - IDX_WIDTH'(1);
            end
          end else begin
            r_shreg  <= r_shreg >> 1;
            r_bitcnt <= r_bitcnt + CNT_W'(1);
          end
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (rd_en)
        r_last_addr <= w_rd_addr;
    end
  end

endmodule

// File: tb/tb_weight_ser_tx.sv
// Bench for weight_ser_tx: per-cycle compare against a stream model plus literal spot checks.
module tb_weight_ser_tx;

  localparam int LENGTH = 16;
`ifdef WEIGHT_TX_PARITY_EN
  localparam int P = LENGTH + 1;
`else
  localparam int P = LENGTH;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  feat = 4'd0;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data = 16'h0;
  logic        S_out, S_valid, busy, done;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [16];

  weight_ser_tx dut (
    .CLK(CLK), .RST(RST), .start(start), .feat(feat),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .S_out(S_out), .S_valid(S_valid), .busy(busy), .done(done),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // synchronous weight RAM
  always @(posedge CLK) if (rd_en) rd_data <= mem[rd_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A stream is accepted when start is seen while no stream is in progress (FIN counts as
  // in progress). Relative to the accepting edge: d=0 fetch, d=1 load, d=2.. payload, then done.
  int   cyc = 0;
  int   acc = 0;
  int   n_bits = 0;
  int   m_feat = 0;
  bit   active = 0;
  logic exp_bits[$];

  always @(posedge CLK or negedge RST) begin
    int old;
    if (!RST) begin
      active = 0;
    end else begin
      old = cyc;
      cyc = cyc + 1;
      if (active) begin
        if (old - acc == n_bits + 2) active = 0;
      end else if (start) begin
        m_feat = int'(feat);
        exp_bits.delete();
        for (int w = m_feat; w >= 0; w--) begin
          for (int b = 0; b < LENGTH; b++) exp_bits.push_back(mem[w][b]);
`ifdef WEIGHT_TX_PARITY_EN
          exp_bits.push_back(^mem[w]);
`endif
        end
        n_bits = exp_bits.size();
        acc    = cyc;
        active = 1;
      end
    end
  end

  // ---------------- scoreboard / compare + collector ----------------
  logic       cap_q[$];
  logic [3:0] addr_log[$];
  int nvalid = 0, done_cnt = 0, rden_cnt = 0;
  int first_cyc = -1, last_cyc = -1, done_cyc = -1;
  logic [3:0] m_last = 4'd0;

  always @(negedge CLK) begin
    logic e_busy, e_done, e_sv, e_so, e_rden;
    logic [3:0] e_addr;
    int d, bi;
    e_busy = 0; e_done = 0; e_sv = 0; e_so = 0; e_rden = 0; e_addr = 4'd0;
    if (!RST) m_last = 4'd0;
    if (RST && active) begin
      d      = cyc - acc;
      e_busy = (d <= n_bits + 1);
      e_done = (d == n_bits + 2);
      e_sv   = (d >= 2) && (d <= n_bits + 1);
      if (e_sv) e_so = exp_bits[d-2];
      if (d == 0) begin
        e_rden = 1; e_addr = 4'(m_feat);
      end else if (e_sv) begin
        bi = d - 2;
        if ((bi % P == P - 3) && (bi / P < m_feat)) begin
          e_rden = 1; e_addr = 4'(m_feat - bi / P - 1);
        end
      end
    end
    if (!e_rden) e_addr = m_last;
    check("busy",    32'(busy),    32'(e_busy));
    check("done",    32'(done),    32'(e_done));
    check("S_valid", 32'(S_valid), 32'(e_sv));
    check("S_out",   32'(S_out),   32'(e_so));
    check("rd_en",   32'(rd_en),   32'(e_rden));
    check("rd_addr", 32'(rd_addr), 32'(e_addr));
    if (e_rden) m_last = e_addr;

    if (S_valid) begin
      cap_q.push_back(S_out);
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      nvalid++;
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (rd_en) begin rden_cnt++; addr_log.push_back(rd_addr); end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_log();
    cap_q.delete(); addr_log.delete();
    nvalid = 0; done_cnt = 0; rden_cnt = 0;
    first_cyc = -1; last_cyc = -1; done_cyc = -1;
  endtask

  task automatic pulse_start(input logic [3:0] f);
    @(negedge CLK); feat = f; start = 1'b1;
    @(negedge CLK); start = 1'b0; feat = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_done(input string name);
    int i;
    i = 0;
    while (done_cnt == 0 && i < 600) begin @(posedge CLK); i++; end
    check({name, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    repeat (3) @(posedge CLK);
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom_range(0, 65535));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] w;
    logic [15:0] ref16;
    int i, f;
    for (int k = 0; k < 16; k++) mem[k] = 16'h0;

    // reset state
    repeat (3) @(negedge CLK);
    check("rst_S_out", 32'(S_out), 32'd0);
    check("rst_S_valid", 32'(S_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    #2 RST = 1'b1;

    // single word A5C3
    clear_log();
    mem[0] = 16'hA5C3;
    pulse_start(4'd0);
    wait_done("w0");
    ref16 = 16'b1010_0101_1100_0011;
    check("w0_nbits", 32'(nvalid), 32'(P));
    check("w0_first_valid", 32'(first_cyc - acc), 32'd2);
    check("w0_no_gap", 32'(last_cyc - first_cyc + 1), 32'(nvalid));
    check("w0_done_cyc", 32'(done_cyc - acc), 32'(P + 2));
    check("w0_done_cnt", 32'(done_cnt), 32'd1);
    check("w0_busy_after", 32'(busy), 32'd0);
    check("w0_rden_cnt", 32'(rden_cnt), 32'd1);
    for (int b = 0; b < LENGTH && b < cap_q.size(); b++)
      check("w0_bit", 32'(cap_q[b]), 32'(ref16[b]));

    // feat=5, weights 1..6
    clear_log();
    for (int k = 0; k < 6; k++) mem[k] = 16'(k + 1);
    pulse_start(4'd5);
    wait_done("f5");
    check("f5_nbits", 32'(nvalid), 32'(6 * P));
    check("f5_no_gap", 32'(last_cyc - first_cyc + 1), 32'(nvalid));
    check("f5_rden_cnt", 32'(rden_cnt), 32'd6);
    for (int k = 0; k < 6 && k < addr_log.size(); k++)
      check("f5_rd_addr_seq", 32'(addr_log[k]), 32'(5 - k));
    for (int k = 0; k < 6 && (k + 1) * P <= cap_q.size(); k++) begin
      w = 16'h0;
      for (int b = 0; b < LENGTH; b++) w[b] = cap_q[k * P + b];
      check("f5_word", 32'(w), 32'(6 - k));
    end

    // feat=15, random weights
    clear_log();
    rand_mem();
    pulse_start(4'd15);
    wait_done("f15");
    check("f15_nbits", 32'(nvalid), 32'(16 * P));
    check("f15_done_cyc", 32'(done_cyc - acc), 32'(16 * P + 2));
    check("f15_no_gap", 32'(last_cyc - first_cyc + 1), 32'(nvalid));

    // start re-pulsed in SHIFT and in FIN
    clear_log();
    rand_mem();
    pulse_start(4'd2);
    i = 0;
    while (cap_q.size() < 20 && i < 200) begin @(posedge CLK); i++; end
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    i = 0;
    while (!done && i < 200) begin @(posedge CLK); #1; i++; end
    start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check("rp_busy_after", 32'(busy), 32'd0);
    check("rp_done_cnt", 32'(done_cnt), 32'd1);
    check("rp_nbits", 32'(nvalid), 32'(3 * P));

    // later start in IDLE plus a few random streams
    for (int t = 0; t < 4; t++) begin
      clear_log();
      rand_mem();
      f = $urandom_range(0, 15);
      pulse_start(4'(f));
      wait_done("rnd");
      check("rnd_nbits", 32'(nvalid), 32'((f + 1) * P));
      check("rnd_done_cnt", 32'(done_cnt), 32'd1);
    end

    // asynchronous reset at bit 40 of a feat=5 stream
    clear_log();
    rand_mem();
    pulse_start(4'd5);
    i = 0;
    while (cap_q.size() < 40 && i < 300) begin @(posedge CLK); i++; end
    #3 RST = 1'b0;
    #1;
    check("ar_S_out", 32'(S_out), 32'd0);
    check("ar_S_valid", 32'(S_valid), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_done", 32'(done), 32'd0);
    check("ar_rd_en", 32'(rd_en), 32'd0);
    check("ar_rd_addr", 32'(rd_addr), 32'd0);
    repeat (3) @(negedge CLK);
    check("ar_no_done", 32'(done_cnt), 32'd0);
    @(negedge CLK); #2 RST = 1'b1;
    clear_log();
    pulse_start(4'd5);
    wait_done("ar_restart");
    check("ar_restart_nbits", 32'(nvalid), 32'(6 * P));
    check("ar_restart_done_cnt", 32'(done_cnt), 32'd1);

    // two words 0x0007 / 0x0003
    clear_log();
    mem[0] = 16'h0007;
    mem[1] = 16'h0003;
    pulse_start(4'd1);
    wait_done("two");
    check("two_nbits", 32'(nvalid), 32'(2 * P));
`ifdef WEIGHT_TX_PARITY_EN
    if (cap_q.size() >= 34) begin
      check("par_word1", 32'(cap_q[16]), 32'd0);
      check("par_word0", 32'(cap_q[33]), 32'd1);
    end
`endif

    repeat (2) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
